// File: rtl/mux2to1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2to1_rr_arbiter
//
// Packet-level round-robin arbiter that owns the select line of a shared 2:1
// multiplexer. A grant is locked for a whole packet, or until MAX_BEATS beats
// have transferred, whichever comes first. On release, priority passes to the
// other requester and the next grant is issued on the same edge, so there is
// no bubble between back-to-back packets.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req0/req1  requester n has a beat available / wants the mux
//   in0/in1    requester data (WIDTH bits)
//   last0/1    current beat is the final beat of its packet
//   out_ready  consumer accepts a beat this cycle
//   out_valid  out carries a valid beat (combinational)
//   out        muxed data: in1 when sel=1, else in0 (combinational)
//   sel        registered mux select, always equal to gnt1
//   gnt0/gnt1  registered grants, never both set
// ---------------------------------------------------------------------------
module mux2to1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             last0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    input  logic             last1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             sel,
    output logic             gnt0,
    output logic             gnt1
);

    // beat_cnt value at which the next transfer forces a release
    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t     state;
    logic       prio;       // requester that wins when both request
    logic [7:0] beat_cnt;   // beats transferred under the current grant

    logic transfer;
    logic cur_last;
    logic release_now;
    logic arb_prio;
    logic arb_any;
    logic arb_pick;

    // The grant registers mirror the BUSY states, so they are used directly
    // to steer the datapath instead of decoding state again.
    always_comb begin
        // NOTE: every signal gets a value on every path through this block;
        // a missing assignment would turn it into a latch.
        out         = sel ? in1 : in0;
        out_valid   = (gnt0 & req0) | (gnt1 & req1);
        transfer    = out_valid & out_ready;
        // Only the owner's last counts; the other requester's last is ignored.
        cur_last    = gnt1 ? last1 : last0;
        release_now = transfer & (cur_last | (beat_cnt == LAST_CNT));

        // From IDLE arbitrate with the stored priority; on a release the
        // other index already has priority for this same-edge re-arbitration.
        arb_prio    = (state == IDLE) ? prio : ~sel;
        arb_any     = req0 | req1;
        arb_pick    = (req0 & req1) ? arb_prio : req1;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            beat_cnt <= 8'd0;
            sel      <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        state <= arb_pick ? BUSY1 : BUSY0;
                        sel   <= arb_pick;
                        gnt0  <= ~arb_pick;
                        gnt1  <= arb_pick;
                    end
                end

                BUSY0, BUSY1: begin
                    if (release_now) begin
                        prio     <= ~sel;
                        beat_cnt <= 8'd0;
                        if (arb_any) begin
                            state <= arb_pick ? BUSY1 : BUSY0;
                            sel   <= arb_pick;
                            gnt0  <= ~arb_pick;
                            gnt1  <= arb_pick;
                        end else begin
                            state <= IDLE;
                            sel   <= 1'b0;
                            gnt0  <= 1'b0;
                            gnt1  <= 1'b0;
                        end
                    end else if (transfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    beat_cnt <= 8'd0;
                    sel      <= 1'b0;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux2to1_rr_arbiter
//
// Two arbiters (MAX_BEATS=4 and MAX_BEATS=1) share one set of inputs. A
// packet-level reference model tracks the owner, the beats sent under the
// current grant and the priority for each, and a scoreboard compares all
// outputs on every falling edge. Directed scenario tasks add their own
// checks against hand-derived constants on the MAX_BEATS=4 instance.
// ---------------------------------------------------------------------------
module tb_mux2to1_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] m_in0 = 8'h00;
    logic [7:0] m_in1 = 8'h00;
    logic       m_last0 = 1'b0;
    logic       m_last1 = 1'b0;
    logic       drv_en = 1'b0;
    logic       drv_clr = 1'b0;
    logic       mon_en = 1'b0;

    wire [7:0] in0, in1;
    wire       last0, last1;
    wire [1:0] ov, sl, g0, g1;
    wire [1:0][7:0] od;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- packet generator ----------------
    // Data beat = {requester, packet number[2:0], beat index[3:0]}
    int        bidx[2]    = '{0, 0};
    int        blen[2]    = '{1, 1};
    int        pcnt[2]    = '{0, 0};
    int        fix_len[2] = '{0, 0};
    logic [1:0] xfer = 2'b00;

    assign in0   = drv_en ? {1'b0, 3'(pcnt[0]), 4'(bidx[0])} : m_in0;
    assign in1   = drv_en ? {1'b1, 3'(pcnt[1]), 4'(bidx[1])} : m_in1;
    assign last0 = drv_en ? (bidx[0] == blen[0] - 1) : m_last0;
    assign last1 = drv_en ? (bidx[1] == blen[1] - 1) : m_last1;

    function automatic int new_len(input int n);
        return (fix_len[n] != 0) ? fix_len[n] : int'($urandom_range(1, 7));
    endfunction

    always @(negedge clk) xfer <= {g1[0] & ov[0] & out_ready, g0[0] & ov[0] & out_ready};

    always begin
        @(posedge clk);
        #2;
        for (int n = 0; n < 2; n++) begin
            if (drv_clr) begin
                bidx[n] <= 0;
                pcnt[n] <= 0;
                blen[n] <= new_len(n);
            end else if (xfer[n]) begin
                if (bidx[n] == blen[n] - 1) begin
                    bidx[n] <= 0;
                    pcnt[n] <= pcnt[n] + 1;
                    blen[n] <= new_len(n);
                end else begin
                    bidx[n] <= bidx[n] + 1;
                end
            end
        end
    end

    // ---------------- DUTs ----------------
    mux2to1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .last0(last0),
        .req1(req1), .in1(in1), .last1(last1),
        .out_ready(out_ready), .out_valid(ov[0]), .out(od[0]),
        .sel(sl[0]), .gnt0(g0[0]), .gnt1(g1[0])
    );

    mux2to1_rr_arbiter #(.WIDTH(8), .MAX_BEATS(1)) dut_mb1 (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .last0(last0),
        .req1(req1), .in1(in1), .last1(last1),
        .out_ready(out_ready), .out_valid(ov[1]), .out(od[1]),
        .sel(sl[1]), .gnt0(g0[1]), .gnt1(g1[1])
    );

    // ---------------- reference model ----------------
    // owner: -1 = nobody, else requester index. sent = beats sent this grant.
    localparam int MB[2] = '{4, 1};
    int m_owner[2] = '{-1, -1};
    int m_sent[2]  = '{0, 0};
    int m_prio[2]  = '{0, 0};

    function automatic int pick(input logic r0, input logic r1, input int p);
        if (r0 && r1) return p;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic void model_step(input int k, output int o, output int s, output int p);
        o = m_owner[k];
        s = m_sent[k];
        p = m_prio[k];
        if (rst) begin
            o = -1; s = 0; p = 0;
        end else if (o < 0) begin
            o = pick(req0, req1, p);
        end else if (((o == 1) ? req1 : req0) && out_ready) begin
            s = s + 1;
            if (((o == 1) ? last1 : last0) || s == MB[k]) begin
                p = 1 - o;
                s = 0;
                o = pick(req0, req1, p);
            end
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int o, s, p;
            model_step(k, o, s, p);
            m_owner[k] <= o;
            m_sent[k]  <= s;
            m_prio[k]  <= p;
        end
    end

    function automatic logic [11:0] model_out(input int k);
        logic v;
        logic [7:0] d;
        v = (m_owner[k] == 0) ? req0 : ((m_owner[k] == 1) ? req1 : 1'b0);
        d = (m_owner[k] == 1) ? in1 : in0;
        return {v, d, (m_owner[k] == 1), (m_owner[k] == 0), (m_owner[k] == 1)};
    endfunction

    // Scoreboard: {out_valid, out, sel, gnt0, gnt1}
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if ({ov[k], od[k], sl[k], g0[k], g1[k]} !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL scoreboard dut%0d t=%0t: got v=%b out=%h sel=%b g0=%b g1=%b, expected {v,out,sel,g0,g1}=%h",
                             k, $time, ov[k], od[k], sl[k], g0[k], g1[k], model_out(k));
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drv_clr = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        drv_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drv_en = 1'b0; req0 = 1'b0; req1 = 1'b0;
        m_in0 = 8'hA5; m_in1 = 8'h5A;
        do_reset(2);
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sl[0], g0[0], g1[0], ov[0]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got sel,g0,g1,valid=%b expected 0000", {sl[0], g0[0], g1[0], ov[0]});
        end
        n_checks++;
        if (od[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected a5", od[0]);
        end
        tick();
    endtask

    task automatic test_single();
        logic [7:0] beats[3] = '{8'h11, 8'h12, 8'h13};
        drv_en = 1'b0;
        m_in0 = 8'h11; m_last0 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (g0[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: gnt0 got %b expected 0 before edge", g0[0]);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            m_in0 = beats[i];
            m_last0 = (i == 2);
            @(negedge clk);
            n_checks++;
            if ({g0[0], ov[0], od[0]} !== {2'b11, beats[i]}) begin
                n_fail++;
                $display("FAIL single_beat%0d: got g0=%b v=%b out=%h expected 1 1 %h", i, g0[0], ov[0], od[0], beats[i]);
            end
            tick();
        end
        // Requester 0 was still requesting alone at the release edge, so it is
        // re-granted; with req0 now low the grant holds and out_valid is 0.
        req0 = 1'b0; m_last0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({g0[0], g1[0], ov[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_regrant: got g0,g1,v=%b expected 100", {g0[0], g1[0], ov[0]});
        end
        tick();
    endtask

    task automatic test_contention();
        drv_en = 1'b1; fix_len[0] = 2; fix_len[1] = 2;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        do_reset(2);
        tick();
        for (int i = 0; i < 8; i++) begin
            logic e1;
            logic [7:0] ed;
            e1 = ((i / 2) % 2) == 1;
            ed = {e1, 3'(i / 4), 4'(i % 2)};
            @(negedge clk);
            n_checks++;
            if ({g0[0], g1[0], sl[0], ov[0], od[0]} !== {~e1, e1, e1, 1'b1, ed}) begin
                n_fail++;
                $display("FAIL contention_c%0d: got g0=%b g1=%b sel=%b v=%b out=%h expected %b %b %b 1 %h",
                         i, g0[0], g1[0], sl[0], ov[0], od[0], ~e1, e1, e1, ed);
            end
            tick();
        end
    endtask

    task automatic test_beat_limit();
        logic [7:0] exp_d[8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h04, 8'h05};
        drv_en = 1'b1; fix_len[0] = 6; fix_len[1] = 2;
        req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
        do_reset(2);
        tick();
        for (int i = 0; i < 8; i++) begin
            logic e1;
            e1 = (i == 4 || i == 5);
            @(negedge clk);
            n_checks++;
            if ({g0[0], g1[0], ov[0], od[0]} !== {~e1, e1, 1'b1, exp_d[i]}) begin
                n_fail++;
                $display("FAIL beat_limit_c%0d: got g0=%b g1=%b v=%b out=%h expected %b %b 1 %h",
                         i, g0[0], g1[0], ov[0], od[0], ~e1, e1, exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        drv_en = 1'b1; fix_len[0] = 2; fix_len[1] = 10;
        req0 = 1'b0; req1 = 1'b1; out_ready = 1'b1;
        do_reset(2);
        tick();   // grant 1 issued; beat 0x80 transfers on the next edge
        tick();
        out_ready = 1'b0; req0 = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req1 = (j != 1);
            @(negedge clk);
            n_checks++;
            if ({g0[0], g1[0], sl[0], ov[0], od[0]} !== {3'b011, req1, 8'h81}) begin
                n_fail++;
                $display("FAIL stall_c%0d: got g0=%b g1=%b sel=%b v=%b out=%h expected 0 1 1 %b 81",
                         j, g0[0], g1[0], sl[0], ov[0], od[0], req1);
            end
            tick();
        end
        out_ready = 1'b1; req1 = 1'b1;
        // One beat went before the stall, so exactly three more fit the limit.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if ({g1[0], od[0]} !== {1'b1, 8'(8'h81 + j)}) begin
                n_fail++;
                $display("FAIL resume_c%0d: got g1=%b out=%h expected 1 %h", j, g1[0], od[0], 8'(8'h81 + j));
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({g0[0], g1[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL resume_handover: got g0,g1=%b expected 10", {g0[0], g1[0]});
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        drv_en = 1'b1; fix_len[0] = 2; fix_len[1] = 4;
        req0 = 1'b0; req1 = 1'b1; out_ready = 1'b1;
        do_reset(2);
        tick();   // grant 1, beat 1 on the bus
        tick();   // beat 2 on the bus
        rst = 1'b1; req0 = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({g0[0], g1[0], sl[0], ov[0]} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_abort: got g0,g1,sel,v=%b expected 0000", {g0[0], g1[0], sl[0], ov[0]});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({g0[0], g1[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_prio: got g0,g1=%b expected 10", {g0[0], g1[0]});
        end
        tick();
    endtask

    task automatic test_random();
        drv_en = 1'b1; fix_len[0] = 0; fix_len[1] = 0;
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            req0      = ($urandom % 4) != 0;
            req1      = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 100) == 0;
            tick();
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_contention();
        test_beat_limit();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
